// File: rtl/reg_bus_reader.sv
// reg_bus_reader: indexed read controller for a tri-state register bus.
// Optional double sampling in CAPTURE: define REG_BUS_READER_DOUBLE_SAMPLE_EN.
module reg_bus_reader #(
    parameter int NrOfBits     = 32,
    parameter int NrOfRegs     = 8,
    parameter int IdxBits      = 3,
    parameter int SettleCycles = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                ReqValid,
    input  logic [IdxBits-1:0]  ReqIndex,
    output logic                ReqReady,
    output logic [NrOfRegs-1:0] cs,
    input  logic [NrOfBits-1:0] BusIn,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [NrOfBits-1:0] RspData,
    output logic [IdxBits-1:0]  RspIndex,
    output logic                RspError,
    output logic                RspMismatch
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        CAPTURE,
        RESPOND
    } state_t;

    state_t             state;
    logic [3:0]         count;
    logic [IdxBits-1:0] idx;
    logic               accept;
    logic               in_range;

`ifdef REG_BUS_READER_DOUBLE_SAMPLE_EN
    logic                second;
    logic [NrOfBits-1:0] first_sample;
`endif

    // Requests are only taken in IDLE on a ticked edge, never during reset.
    assign ReqReady = (state == IDLE) && Tick && !Reset;
    assign accept   = ReqValid && ReqReady;
    assign in_range = 32'(ReqIndex) < NrOfRegs;

    // Read sequencer: select, settle, capture, then hold the response.
    // The counter holds the SELECT cycles still to go after the current one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= '0;
            idx         <= '0;
            cs          <= '1;
            RspValid    <= 1'b0;
            RspData     <= '0;
            RspIndex    <= '0;
            RspError    <= 1'b0;
            RspMismatch <= 1'b0;
`ifdef REG_BUS_READER_DOUBLE_SAMPLE_EN
            second       <= 1'b0;
            first_sample <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= ReqIndex;
                        if (in_range) begin
                            cs <= ~(NrOfRegs'(1) << ReqIndex);
                            if (SettleCycles == 0) begin
                                state <= CAPTURE;
                            end else begin
                                state <= SELECT;
                                count <= 4'(SettleCycles - 1);
                            end
                        end else begin
                            state       <= RESPOND;
                            RspValid    <= 1'b1;
                            RspData     <= '0;
                            RspIndex    <= ReqIndex;
                            RspError    <= 1'b1;
                            RspMismatch <= 1'b0;
                        end
                    end
                end
                SELECT: begin
                    if (Tick) begin
                        if (count == 4'd0) begin
                            state <= CAPTURE;
                        end else begin
                            count <= count - 4'd1;
                        end
                    end
                end
                CAPTURE: begin
                    if (Tick) begin
`ifdef REG_BUS_READER_DOUBLE_SAMPLE_EN
                        if (!second) begin
                            first_sample <= BusIn;
                            second       <= 1'b1;
                        end else begin
                            second      <= 1'b0;
                            cs          <= '1;
                            state       <= RESPOND;
                            RspValid    <= 1'b1;
                            RspData     <= BusIn;
                            RspIndex    <= idx;
                            RspError    <= 1'b0;
                            RspMismatch <= (BusIn != first_sample);
                        end
`else
                        cs          <= '1;
                        state       <= RESPOND;
                        RspValid    <= 1'b1;
                        RspData     <= BusIn;
                        RspIndex    <= idx;
                        RspError    <= 1'b0;
                        RspMismatch <= 1'b0;
`endif
                    end
                end
                RESPOND: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cs    <= '1;
                end
            endcase
        end
    end

endmodule
